// File: rtl/fv_replay_scheduler_if.sv
// ----------------------------------------------------------------------------
// fv_replay_scheduler_if
//
// Bundles the control/handshake signals between the FV replay scheduler and
// its neighbours: the aggregation datapath (start, iter_done, run_start) and
// the two Big FV wrappers (buf_sel, clr_wen, clr_addr).
//
// Parameters:
//   ITER_W - width of replay_Iter
//   ADDR_W - width of clr_addr
//
// Signals:
//   start         - single-cycle task request
//   iter_done     - datapath pulse marking end of the current iteration
//   replay_Iter   - current iteration index
//   buf_sel       - 0: wrapper0 source / wrapper1 destination, 1: swapped
//   run_start     - one-cycle datapath launch pulse
//   busy          - scheduler is clearing, running or swapping
//   task_complete - all iterations finished
//   clr_wen       - destination-bank clear write enable
//   clr_addr      - destination-bank clear address (data is implicitly zero)
//
// Modports:
//   master - the scheduler side (drives the status/control outputs)
//   slave  - the surrounding logic (drives start and iter_done)
// ----------------------------------------------------------------------------
interface fv_replay_scheduler_if #(
    parameter int unsigned ITER_W = 2,
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic              iter_done;
    logic [ITER_W-1:0] replay_Iter;
    logic              buf_sel;
    logic              run_start;
    logic              busy;
    logic              task_complete;
    logic              clr_wen;
    logic [ADDR_W-1:0] clr_addr;

    modport master (
        input  start,
        input  iter_done,
        output replay_Iter,
        output buf_sel,
        output run_start,
        output busy,
        output task_complete,
        output clr_wen,
        output clr_addr
    );

    modport slave (
        output start,
        output iter_done,
        input  replay_Iter,
        input  buf_sel,
        input  run_start,
        input  busy,
        input  task_complete,
        input  clr_wen,
        input  clr_addr
    );
endinterface

// File: rtl/fv_replay_scheduler.sv
// ----------------------------------------------------------------------------
// fv_replay_scheduler
//
// Sequences the multi-iteration replay of the GNN feature-value datapath.
// Owns the replay_Iter counter and the task_complete flag, and decides which
// Big FV wrapper is read source and which is write destination. Before each
// iteration it can zero-clear the destination buffer, then launches the
// datapath and waits for iter_done.
//
// Configuration macro:
//   FV_CLEAR_EN - when defined, a CLEAR phase of DEPTH cycles precedes every
//                 iteration; when undefined, CLEAR is removed and clr_wen /
//                 clr_addr are tied to zero.
//
// Parameters:
//   NUM_ITER - replay iterations per task
//   ITER_W   - width of replay_Iter (2**ITER_W >= NUM_ITER)
//   DEPTH    - words per FV SRAM bank
//   ADDR_W   - clear address width (log2(DEPTH))
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - fv_replay_scheduler_if.master: start / iter_done in, replay_Iter,
//           buf_sel, run_start, busy, task_complete, clr_wen, clr_addr out.
//           All outputs are driven straight from flops.
// ----------------------------------------------------------------------------
module fv_replay_scheduler #(
    parameter int unsigned NUM_ITER = 4,
    parameter int unsigned ITER_W   = 2,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    fv_replay_scheduler_if.master      bus
);

    // Elaboration-time sanity checks on the parameter set.
    if ((64'd1 << ITER_W) < 64'(NUM_ITER)) begin : g_bad_iter_w
        $error("ITER_W too narrow for NUM_ITER");
    end
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for DEPTH");
    end

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSwap,
        StDone
    } state_e;

    localparam logic [ITER_W-1:0] LastIter = ITER_W'(NUM_ITER - 1);

`ifdef FV_CLEAR_EN
    // Every iteration (and every task) is entered through the clear phase.
    localparam state_e FirstSt = StClear;
`else
    localparam state_e FirstSt = StRun;
`endif

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              buf_q, buf_d;
    logic              run_start_q, run_start_d;
    logic              busy_q, busy_d;
    logic              task_complete_q, task_complete_d;
    logic              clr_last;

    // ------------------------------------------------------------------
    // Main sequencer: next state plus the registered status outputs, all
    // derived from the next state so they line up with it cycle-for-cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        buf_d   = buf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = FirstSt;
                    iter_d  = '0;
                    buf_d   = 1'b0;
                end
            end
            StClear: begin
                if (clr_last) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A pulse landing on the launch cycle belongs to no iteration.
                if (bus.iter_done && !run_start_q) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                if (iter_q == LastIter) begin
                    state_d = StDone;
                end else begin
                    state_d = FirstSt;
                    iter_d  = iter_q + ITER_W'(1);
                    buf_d   = ~buf_q;
                end
            end
            StDone: begin
                if (bus.start) begin
                    state_d = FirstSt;
                    iter_d  = '0;
                    buf_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        run_start_d     = (state_d == StRun) && (state_q != StRun);
        busy_d          = (state_d == StClear) || (state_d == StRun) || (state_d == StSwap);
        task_complete_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            iter_q          <= '0;
            buf_q           <= 1'b0;
            run_start_q     <= 1'b0;
            busy_q          <= 1'b0;
            task_complete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            iter_q          <= iter_d;
            buf_q           <= buf_d;
            run_start_q     <= run_start_d;
            busy_q          <= busy_d;
            task_complete_q <= task_complete_d;
        end
    end

    // ------------------------------------------------------------------
    // Destination clear engine.
    // ------------------------------------------------------------------
`ifdef FV_CLEAR_EN
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic              clr_wen_q, clr_wen_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    assign clr_last = (clr_addr_q == LastAddr);

    always_comb begin
        clr_wen_d = (state_d == StClear);
        // Count only while staying in CLEAR; entering or leaving restarts at 0
        // so the address never wraps and a new clear always begins at 0.
        if ((state_q == StClear) && (state_d == StClear)) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
        end else begin
            clr_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_wen_q  <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_wen_q  <= clr_wen_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign bus.clr_wen  = clr_wen_q;
    assign bus.clr_addr = clr_addr_q;
`else
    assign clr_last     = 1'b0;
    assign bus.clr_wen  = 1'b0;
    assign bus.clr_addr = '0;
`endif

    assign bus.replay_Iter   = iter_q;
    assign bus.buf_sel       = buf_q;
    assign bus.run_start     = run_start_q;
    assign bus.busy          = busy_q;
    assign bus.task_complete = task_complete_q;

endmodule
